// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind the core's load/store port,
// with byte-lane writes, programmable wait states and access-error reporting.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0]  mem_width,
  output logic [31:0] mem_rd_data,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_rd;
  logic        r_wr;
  logic [3:0]  r_cnt;
  logic [31:0] r_rd_data;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req;
  logic        w_abort;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_mask;
  logic        w_rd;
  logic        w_wr;
  logic [31:0] w_off;
  logic        w_range_ok;
  logic        w_mask_ok;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic        w_enter_resp;
  logic        w_do_write;
  logic        w_do_read;

  assign w_req   = mem_rd_en | mem_wr_en;
  assign w_abort = ~mem_rd_en & ~mem_wr_en;

  // With zero wait states IDLE jumps straight to RESP, so the access is judged
  // on the live inputs in IDLE and on the latched copy everywhere else.
  always_comb begin
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_mask  = r_mask;
    w_rd    = r_rd;
    w_wr    = r_wr;
    if (r_state == S_IDLE) begin
      w_addr  = mem_addr;
      w_wdata = mem_wr_data;
      w_mask  = mem_width;
      w_rd    = mem_rd_en;
      w_wr    = mem_wr_en;
    end
  end

  assign w_off      = w_addr - BASE_ADDR;
  assign w_range_ok = ({1'b0, w_off} < LIMIT);
  assign w_idx      = w_off[AW+1:2];

  always_comb begin
    w_mask_ok = 1'b0;
    case (w_mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_mask_ok = 1'b1;
      default:                   w_mask_ok = 1'b0;
    endcase
  end

  assign w_err = ~w_range_ok | ~w_mask_ok | (w_rd & w_wr);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = (WS == 4'd0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: the response is resolved on the edge that enters RESP,
  // so the registered outputs are valid for the whole RESP cycle.
  always_comb begin
    w_enter_resp = 1'b0;
    w_do_write   = 1'b0;
    w_do_read    = 1'b0;
    if (w_next == S_RESP) begin
      w_enter_resp = 1'b1;
      w_do_write   = reset & w_wr & ~w_err;
      w_do_read    = w_rd & ~w_err;
    end
  end

  // Request capture, wait counter and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_mask    <= 4'd0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_cnt     <= 4'd0;
      r_rd_data <= 32'd0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wr_data;
        r_mask  <= mem_width;
        r_rd    <= mem_rd_en;
        r_wr    <= mem_wr_en;
        r_cnt   <= WS;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp & w_err;
      if (w_do_read) begin
        r_rd_data <= r_mem[w_idx];
      end
    end
  end

  // RAM array is never reset; only the enabled byte lanes are written
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_rd_data = r_rd_data;
  assign mem_ready   = r_ready;
  assign mem_err     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four builds (WAIT_STATES 1, 0, 15, 3)
// exercising lanes, errors, latency, abort and asynchronous reset.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 16;
  localparam logic [15:0] WS_PACK = {4'd3, 4'd15, 4'd0, 4'd1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en   [4];
  logic        wr_en   [4];
  logic [31:0] addr    [4];
  logic [31:0] wdata   [4];
  logic [3:0]  mask    [4];
  logic [31:0] rd_data [4];
  logic        ready   [4];
  logic        err     [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_STATES (32'(WS_PACK[g*4 +: 4]))
    ) u_dut (
      .clk         (clk),
      .reset       (rst_n),
      .mem_rd_en   (rd_en[g]),
      .mem_wr_en   (wr_en[g]),
      .mem_addr    (addr[g]),
      .mem_wr_data (wdata[g]),
      .mem_width   (mask[g]),
      .mem_rd_data (rd_data[g]),
      .mem_ready   (ready[g]),
      .mem_err     (err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One handshake from a negedge: drive, wait for mem_ready, check, release.
  task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int  n;
    bit  seen;
    rd_en[d] = rd;
    wr_en[d] = wr;
    addr[d]  = a;
    wdata[d] = wd;
    mask[d]  = m;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready[d]) seen = 1'b1;
    end
    rd_en[d] = 1'b0;
    wr_en[d] = 1'b0;
    check({tag, "_lat"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    check({tag, "_rd"}, rd_data[d], exp_rd);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(ready[d]), 32'd0);
  endtask

  task automatic watch_quiet(input int d, input int ncyc, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (ready[d]) hits++;
      @(negedge clk);
    end
    check({tag, "_noready"}, 32'(hits), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      rd_en[d] = 1'b0;
      wr_en[d] = 1'b0;
      addr[d]  = 32'd0;
      wdata[d] = 32'd0;
      mask[d]  = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst%0d_rd", d), rd_data[d], 32'd0);
      check($sformatf("rst%0d_rdy", d), 32'(ready[d]), 32'd0);
      check($sformatf("rst%0d_err", d), 32'(err[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // WAIT_STATES=1: full word, lanes, errors
    access(0, 0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 2, 0, 32'h0, "w_full");
    access(0, 1, 0, BASE + 32'h10, 32'h0,         4'b1111, 2, 0, 32'hDEAD_BEEF, "r_full");
    access(0, 0, 1, BASE + 32'h10, 32'h0000_AA00, 4'b0010, 2, 0, 32'hDEAD_BEEF, "w_b1");
    access(0, 0, 1, BASE + 32'h10, 32'h1234_0000, 4'b1100, 2, 0, 32'hDEAD_BEEF, "w_hi");
    access(0, 1, 0, BASE + 32'h10, 32'h0,         4'b1111, 2, 0, 32'h1234_AAEF, "r_lanes");
    access(0, 1, 0, BASE + 32'h40, 32'h0,         4'b1111, 2, 1, 32'h1234_AAEF, "r_oob_hi");
    access(0, 1, 0, BASE - 32'h4,  32'h0,         4'b1111, 2, 1, 32'h1234_AAEF, "r_oob_lo");
    access(0, 0, 1, BASE + 32'h3C, 32'hCAFE_F00D, 4'b1111, 2, 0, 32'h1234_AAEF, "w_last");
    access(0, 1, 0, BASE + 32'h3F, 32'h0,         4'b1111, 2, 0, 32'hCAFE_F00D, "r_last");
    access(0, 0, 1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0101, 2, 1, 32'hCAFE_F00D, "w_badmask");
    access(0, 1, 1, BASE + 32'h10, 32'h0000_0000, 4'b1111, 2, 1, 32'hCAFE_F00D, "rw_both");
    access(0, 1, 0, BASE + 32'h10, 32'h0,         4'b1111, 2, 0, 32'h1234_AAEF, "r_intact");
    access(0, 0, 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b1111, 2, 0, 32'h1234_AAEF, "w_ones");
    access(0, 0, 1, BASE + 32'h20, 32'h0000_5678, 4'b0011, 2, 0, 32'h1234_AAEF, "w_lo");
    access(0, 0, 1, BASE + 32'h20, 32'h0000_0000, 4'b1000, 2, 0, 32'h1234_AAEF, "w_b3");
    access(0, 1, 0, BASE + 32'h20, 32'h0,         4'b1111, 2, 0, 32'h00FF_5678, "r_mix");

    // WAIT_STATES=0 and 15: latency and back-to-back consecutive words
    for (int i = 0; i < 4; i++)
      access(1, 0, 1, BASE + 32'(4*i), 32'(32'h1111_1111 * (i+1)), 4'b1111, 1, 0, 32'h0,
             $sformatf("ws0_w%0d", i));
    for (int i = 0; i < 4; i++)
      access(1, 1, 0, BASE + 32'(4*i), 32'h0, 4'b1111, 1, 0, 32'(32'h1111_1111 * (i+1)),
             $sformatf("ws0_r%0d", i));
    access(1, 0, 1, BASE + 32'h8, 32'hABCD_0123, 4'b1111, 1, 0, 32'h4444_4444, "ws0_raw_w");
    access(1, 1, 0, BASE + 32'h8, 32'h0,         4'b1111, 1, 0, 32'hABCD_0123, "ws0_raw_r");
    for (int i = 0; i < 4; i++)
      access(2, 0, 1, BASE + 32'(4*i + 32), 32'(32'h0101_0101 << i), 4'b1111, 16, 0, 32'h0,
             $sformatf("ws15_w%0d", i));
    for (int i = 0; i < 4; i++)
      access(2, 1, 0, BASE + 32'(4*i + 32), 32'h0, 4'b1111, 16, 0, 32'(32'h0101_0101 << i),
             $sformatf("ws15_r%0d", i));

    // WAIT_STATES=3: abort during BUSY leaves the old word
    access(3, 0, 1, BASE + 32'h8, 32'hA5A5_A5A5, 4'b1111, 4, 0, 32'h0, "ws3_w");
    wr_en[3] = 1'b1;
    addr[3]  = BASE + 32'h8;
    wdata[3] = 32'h0BAD_BEEF;
    mask[3]  = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_en[3] = 1'b0;
    watch_quiet(3, 10, "abort");
    access(3, 1, 0, BASE + 32'h8, 32'h0, 4'b1111, 4, 0, 32'hA5A5_A5A5, "abort_r");

    // Asynchronous reset in the middle of a pending write
    wr_en[3] = 1'b1;
    addr[3]  = BASE + 32'h8;
    wdata[3] = 32'h0000_0055;
    mask[3]  = 4'b1111;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rd", rd_data[3], 32'h0);
    check("arst_rdy", 32'(ready[3]), 32'd0);
    check("arst_err", 32'(err[3]), 32'd0);
    wr_en[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(3, 8, "arst");
    access(3, 1, 0, BASE + 32'h8, 32'h0, 4'b1111, 4, 0, 32'hA5A5_A5A5, "arst_r");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's load/store interface (mem_rd_en / mem_wr_en / mem_addr / mem_wr_data / mem_width → mem_rd_data).
- Holds a word-organised RAM, applies byte-lane writes, and returns read data after a programmable number of wait states.
- Signals completion with mem_ready and flags illegal accesses with mem_err.
- Sits beside the core in the top-level wrapper, between the core's data port and the platform memory map.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_STATES, 1, extra cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_rd_en  input  1  read request; held high by the initiator until mem_ready.
- mem_wr_en  input  1  write request; held high by the initiator until mem_ready.
- mem_addr  input  32  byte address; bits [1:0] ignored for indexing.
- mem_wr_data  input  32  write data, already positioned on its byte lanes.
- mem_width  input  4  byte-lane enable mask for the addressed word (bit n = byte n).
- mem_rd_data  output  32  full read word; valid while mem_ready=1 for a read, held afterwards.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  high together with mem_ready when the access was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; mem_rd_data=0, mem_ready=0, mem_err=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-access aborts it; no write is committed.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_rd_en|mem_wr_en=1, latch addr, wr_data, mask and op; load counter=WAIT_STATES.
  - Go to BUSY if WAIT_STATES>0, else to RESP.
  - If no request, stay in IDLE.
- BUSY:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - If both enables drop while in BUSY, abort to IDLE: no write, no mem_ready.
- RESP (exactly one cycle): mem_ready=1, then return to IDLE.
  - Write: commit the masked lanes to RAM on this edge.
  - Read: mem_rd_data = RAM word.
- Latency: mem_ready asserts WAIT_STATES+1 cycles after the cycle in which the request is first sampled in IDLE.
- The initiator deasserts its enables on the cycle after mem_ready. Enables still high in the following IDLE cycle are treated as a new access.
- Error conditions, evaluated on latched values. On error: mem_err=1 with mem_ready, no RAM write, mem_rd_data unchanged; the wait states are still honoured.
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Mask not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - mem_rd_en and mem_wr_en both high.
- Index = (addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; modular 32-bit subtraction.
- mem_rd_data is updated only on successful reads and holds its value otherwise, including across writes and errors.
- Read-after-write to the same word in back-to-back accesses returns the newly written data.
- Inputs are ignored in BUSY/RESP except for the abort check.

Test Plan:
- Reset, WAIT_STATES=1: write 0xDEADBEEF mask 1111 to 0x10, then read 0x10 → each mem_ready exactly 2 cycles after request; read returns 0xDEADBEEF, mem_err=0.
- Byte/half lanes: after the first scenario, write 0x0000_AA00 mask 0010, then 0x1234_0000 mask 1100 → read returns 0x1234AAEF.
- Errors:
  - Read address BASE_ADDR+4*DEPTH_WORDS → mem_ready=1, mem_err=1, mem_rd_data unchanged.
  - Write mask 0101 → mem_err=1, word contents unchanged.
  - rd_en=wr_en=1 → mem_err=1, no write.
- WAIT_STATES=0 and WAIT_STATES=15 builds: mem_ready at 1 and 16 cycles after request respectively; back-to-back reads of 4 consecutive words return the correct data.
- Abort: drop mem_wr_en during BUSY (WAIT_STATES=3) → no mem_ready; later read shows old data.
- Reset asserted asynchronously mid-BUSY (write 0x55 pending) → outputs 0 immediately, FSM in IDLE, no write committed; later read shows old data.
